// File: rtl/pll_lock_monitor_if.sv
// PLL lock monitor signal bundle: PLL lock in, qualified reset and status out.
interface pll_lock_monitor_if #(
    parameter int W_COUNT = 8
);
    logic               locked_async;
    logic               lock_loss_clear;
    logic               pll_resetb;
    logic               sys_rst_out;
    logic               lock_stable;
    logic [W_COUNT-1:0] lock_loss_count;
    logic [W_COUNT-1:0] retry_count;

    modport master (
        output locked_async,
        output lock_loss_clear,
        input  pll_resetb,
        input  sys_rst_out,
        input  lock_stable,
        input  lock_loss_count,
        input  retry_count
    );

    modport slave (
        input  locked_async,
        input  lock_loss_clear,
        output pll_resetb,
        output sys_rst_out,
        output lock_stable,
        output lock_loss_count,
        output retry_count
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// Qualifies PLL LOCK into a system reset and counts lock losses.
// Define PLL_LOCK_MONITOR_RETRY_EN to enable PLL RESETB retry on lock timeout.
module pll_lock_monitor #(
    parameter int SYNC_STAGES       = 2,
    parameter int LOCK_HOLD_CYCLES  = 1024,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int TIMEOUT_CYCLES    = 65536,
    parameter int PLL_RST_CYCLES    = 4,
    parameter int W_COUNT           = 8
) (
    input logic               clk,
    input logic               rst,
    pll_lock_monitor_if.slave mon
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = max2(max2(LOCK_HOLD_CYCLES, RESET_HOLD_CYCLES),
                               max2(TIMEOUT_CYCLES, PLL_RST_CYCLES));
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] LH_LAST = CW'(LOCK_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RH_LAST = CW'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        QUALIFY,
        RELEASE,
        RUN
`ifdef PLL_LOCK_MONITOR_RETRY_EN
        , RESET_PLL
`endif
    } state_t;

`ifdef PLL_LOCK_MONITOR_RETRY_EN
    localparam state_t RST_STATE = RESET_PLL;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
`else
    localparam state_t RST_STATE = WAIT_LOCK;
`endif

    localparam logic [W_COUNT-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_sync;
    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic                   loss;
    logic                   retry_inc;

    assign lock_sync = sync_q[SYNC_STAGES-1];
    assign loss      = (state_q == RUN) && !lock_sync;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], mon.locked_async};
    end

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        unique case (state_q)
`ifdef PLL_LOCK_MONITOR_RETRY_EN
            RESET_PLL: begin
                if (cnt_q == PR_LAST) state_d = WAIT_LOCK;
            end
`endif
            WAIT_LOCK: begin
                if (lock_sync) begin
                    state_d = QUALIFY;
`ifdef PLL_LOCK_MONITOR_RETRY_EN
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RESET_PLL;
                    retry_inc = 1'b1;
`endif
                end
            end
            QUALIFY: begin
                if (!lock_sync)          state_d = WAIT_LOCK;
                else if (cnt_q == LH_LAST) state_d = RELEASE;
            end
            RELEASE: begin
                if (!lock_sync)          state_d = WAIT_LOCK;
                else if (cnt_q == RH_LAST) state_d = RUN;
            end
            RUN: begin
                if (!lock_sync) state_d = WAIT_LOCK;
            end
            default: state_d = RST_STATE;
        endcase
    end

    // Shared counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mon.sys_rst_out     <= 1'b1;
            mon.lock_stable     <= 1'b0;
            mon.lock_loss_count <= '0;
        end else begin
            mon.sys_rst_out <= (state_d != RUN);
            mon.lock_stable <= (state_d == RUN);
            if (mon.lock_loss_clear)
                mon.lock_loss_count <= loss ? W_COUNT'(1) : '0;
            else if (loss && mon.lock_loss_count != CNT_MAX)
                mon.lock_loss_count <= mon.lock_loss_count + 1'b1;
        end
    end

`ifdef PLL_LOCK_MONITOR_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mon.pll_resetb  <= 1'b0;
            mon.retry_count <= '0;
        end else begin
            mon.pll_resetb <= (state_d != RESET_PLL);
            if (retry_inc && mon.retry_count != CNT_MAX)
                mon.retry_count <= mon.retry_count + 1'b1;
        end
    end
`else
    assign mon.pll_resetb  = 1'b1;
    assign mon.retry_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor; retry checks follow PLL_LOCK_MONITOR_RETRY_EN.
module tb_pll_lock_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pll_lock_monitor_if #(.W_COUNT(2)) mon ();

    pll_lock_monitor #(
        .SYNC_STAGES(2),
        .LOCK_HOLD_CYCLES(8),
        .RESET_HOLD_CYCLES(4),
        .TIMEOUT_CYCLES(32),
        .PLL_RST_CYCLES(4),
        .W_COUNT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(mon)
    );

    always #5 clk = ~clk;

`ifdef PLL_LOCK_MONITOR_RETRY_EN
    localparam logic RST_RESETB = 1'b0;
`else
    localparam logic RST_RESETB = 1'b1;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rst_out"}, 32'(mon.sys_rst_out), 32'd1);
        check({tag, "_stable"}, 32'(mon.lock_stable), 32'd0);
        check({tag, "_loss"}, 32'(mon.lock_loss_count), 32'd0);
        check({tag, "_retry"}, 32'(mon.retry_count), 32'd0);
        check({tag, "_resetb"}, 32'(mon.pll_resetb), 32'(RST_RESETB));
    endtask

    // Reset, then land in WAIT_LOCK with an idle counter.
    task automatic do_reset();
        rst = 1'b1;
        mon.locked_async    = 1'b0;
        mon.lock_loss_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
`ifdef PLL_LOCK_MONITOR_RETRY_EN
        repeat (4) tick();
`endif
    endtask

    // Raise lock and check release exactly on the 15th edge.
    task automatic lock_and_check(input string tag);
        mon.locked_async = 1'b1;
        repeat (14) tick();
        check({tag, "_pre_rst"}, 32'(mon.sys_rst_out), 32'd1);
        check({tag, "_pre_stable"}, 32'(mon.lock_stable), 32'd0);
        tick();
        check({tag, "_rel_rst"}, 32'(mon.sys_rst_out), 32'd0);
        check({tag, "_rel_stable"}, 32'(mon.lock_stable), 32'd1);
    endtask

    // Drop lock from RUN; reset must assert on the 3rd edge.
    task automatic drop_and_check(input string tag, input logic [1:0] exp_cnt,
                                  input logic clr_on_loss);
        mon.locked_async = 1'b0;
        tick();
        tick();
        check({tag, "_still_run"}, 32'(mon.sys_rst_out), 32'd0);
        mon.lock_loss_clear = clr_on_loss;
        tick();
        mon.lock_loss_clear = 1'b0;
        check({tag, "_rst"}, 32'(mon.sys_rst_out), 32'd1);
        check({tag, "_stable"}, 32'(mon.lock_stable), 32'd0);
        check({tag, "_cnt"}, 32'(mon.lock_loss_count), 32'(exp_cnt));
    endtask

    initial begin
        logic [1:0] exp_loss [4];
        exp_loss[0] = 2'd1;
        exp_loss[1] = 2'd2;
        exp_loss[2] = 2'd3;
        exp_loss[3] = 2'd3;
        mon.locked_async    = 1'b0;
        mon.lock_loss_clear = 1'b0;

        // Reset values
        tick();
        check_reset_vals("reset");

        // 1. basic lock
        do_reset();
        lock_and_check("basic");
        check("basic_loss", 32'(mon.lock_loss_count), 32'd0);

        // 2. glitch in QUALIFY
        do_reset();
        mon.locked_async = 1'b1;
        repeat (5) tick();
        mon.locked_async = 1'b0;
        tick();
        lock_and_check("glitch");
        check("glitch_loss", 32'(mon.lock_loss_count), 32'd0);

        // 3. repeated loss in RUN, count saturates
        for (int i = 0; i < 4; i++) begin
            drop_and_check($sformatf("loss%0d", i), exp_loss[i], 1'b0);
            lock_and_check($sformatf("relock%0d", i));
        end

        // 4. clear alone, then clear coincident with a loss
        mon.lock_loss_clear = 1'b1;
        tick();
        mon.lock_loss_clear = 1'b0;
        check("clear_alone", 32'(mon.lock_loss_count), 32'd0);
        drop_and_check("loss_after_clr", 2'd1, 1'b0);
        lock_and_check("relock_clr");
        drop_and_check("clr_with_loss", 2'd1, 1'b1);
        lock_and_check("relock_clr2");

        // 6a. rst in RELEASE
        do_reset();
        mon.locked_async = 1'b1;
        repeat (12) tick();
        check("in_release_rst", 32'(mon.sys_rst_out), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_vals("rst_release");
        do_reset();
        lock_and_check("after_rel_rst");

        // 6b. rst in RUN with a nonzero loss count
        drop_and_check("pre_run_rst", 2'd1, 1'b0);
        lock_and_check("pre_run_rst_lock");
        rst = 1'b1;
        tick();
        check_reset_vals("rst_run");
        do_reset();
        lock_and_check("after_run_rst");

        // 5. lock never arrives
        rst = 1'b1;
        mon.locked_async = 1'b0;
        tick();
        rst = 1'b0;
`ifdef PLL_LOCK_MONITOR_RETRY_EN
        begin
            logic [1:0] exp_retry [4];
            exp_retry[0] = 2'd1;
            exp_retry[1] = 2'd2;
            exp_retry[2] = 2'd3;
            exp_retry[3] = 2'd3;
            repeat (3) tick();
            check("rp_init_low", 32'(mon.pll_resetb), 32'd0);
            tick();
            check("rp_init_high", 32'(mon.pll_resetb), 32'd1);
            for (int i = 0; i < 4; i++) begin
                repeat (31) tick();
                check($sformatf("rp%0d_pre", i), 32'(mon.pll_resetb), 32'd1);
                tick();
                check($sformatf("rp%0d_low", i), 32'(mon.pll_resetb), 32'd0);
                check($sformatf("rp%0d_cnt", i), 32'(mon.retry_count),
                      32'(exp_retry[i]));
                repeat (3) tick();
                check($sformatf("rp%0d_end", i), 32'(mon.pll_resetb), 32'd0);
                tick();
                check($sformatf("rp%0d_high", i), 32'(mon.pll_resetb), 32'd1);
            end
            check("rp_sys_rst", 32'(mon.sys_rst_out), 32'd1);
        end
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i % 10 == 9) begin
                check($sformatf("noretry_resetb%0d", i), 32'(mon.pll_resetb), 32'd1);
                check($sformatf("noretry_cnt%0d", i), 32'(mon.retry_count), 32'd0);
                check($sformatf("noretry_rst%0d", i), 32'(mon.sys_rst_out), 32'd1);
            end
        end
        lock_and_check("late_lock");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
